// File: rtl/mem_wb_pkg.sv
// Shared MEM/WB definitions: register-file constants, default widths and the
// write-enable sanitiser also used by the ID-stage forwarding logic.
package mem_wb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int MAX_PORTS  = 4;
  localparam int MAX_ADDR_W = 16;

  localparam logic [DEF_DATA_W-1:0] ZERO_WORD    = '0;
  localparam logic [DEF_ADDR_W-1:0] NOP_REG_ADDR = '0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  typedef logic [MAX_PORTS-1:0][MAX_ADDR_W-1:0] wd_vec_t;
  typedef logic [MAX_PORTS-1:0]                 wen_vec_t;

  // Drops writes to r0, and drops a channel whose address is rewritten by a
  // higher-indexed enabled channel. Unused channels must come in disabled.
  function automatic wen_vec_t sanitize_wreg(input wd_vec_t wd, input wen_vec_t wreg);
    wen_vec_t en;
    for (int i = 0; i < MAX_PORTS; i++) begin
      en[i] = (wreg[i] && wd[i] != MAX_ADDR_W'(NOP_REG_ADDR)) ? WRITE_ENABLE : WRITE_DISABLE;
      for (int j = i + 1; j < MAX_PORTS; j++)
        if (wreg[j] && wd[j] == wd[i]) en[i] = WRITE_DISABLE;
    end
    return en;
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One payload slot (write data, destination, enables) with a valid bit.
// clear wins over load and also zeroes the enables so an empty slot never writes.
module pipe_skid_slot
  import mem_wb_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_PORTS = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic                        clear,
  input  logic [NUM_PORTS*DATA_W-1:0] d_wdata,
  input  logic [NUM_PORTS*ADDR_W-1:0] d_wd,
  input  logic [NUM_PORTS-1:0]        d_wreg,
  output logic                        valid,
  output logic [NUM_PORTS*DATA_W-1:0] q_wdata,
  output logic [NUM_PORTS*ADDR_W-1:0] q_wd,
  output logic [NUM_PORTS-1:0]        q_wreg
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= 1'b0;
      q_wdata <= '0;
      q_wd    <= '0;
      q_wreg  <= {NUM_PORTS{WRITE_DISABLE}};
    end else if (clear) begin
      valid  <= 1'b0;
      q_wreg <= {NUM_PORTS{WRITE_DISABLE}};
    end else if (load) begin
      valid   <= 1'b1;
      q_wdata <= d_wdata;
      q_wd    <= d_wd;
      q_wreg  <= d_wreg;
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with valid/ready, flush and write-enable sanitising.
// Define MEM_WB_SKID_EN for a second slot and a registered mem_ready.
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_PORTS = 1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        flush,
  input  logic                        mem_valid,
  output logic                        mem_ready,
  input  logic [NUM_PORTS*DATA_W-1:0] mem_wdata,
  input  logic [NUM_PORTS*ADDR_W-1:0] mem_wd,
  input  logic [NUM_PORTS-1:0]        mem_wreg,
  output logic                        wb_valid,
  input  logic                        wb_ready,
  output logic [NUM_PORTS*DATA_W-1:0] wb_wdata,
  output logic [NUM_PORTS*ADDR_W-1:0] wb_wd,
  output logic [NUM_PORTS-1:0]        wb_wreg
);

  logic                        accept, xfer;
  wd_vec_t                     wd_pad;
  wen_vec_t                    wreg_pad, san_full;
  logic [NUM_PORTS-1:0]        san_wreg;
  logic                        unused_san;

  logic                        out_valid, out_load, out_clear;
  logic [NUM_PORTS*DATA_W-1:0] out_d_wdata;
  logic [NUM_PORTS*ADDR_W-1:0] out_d_wd;
  logic [NUM_PORTS-1:0]        out_d_wreg;

  // Widen the channels to the package's fixed shape so one sanitiser serves all builds.
  always_comb begin
    wd_pad   = '0;
    wreg_pad = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      wd_pad[i][ADDR_W-1:0] = mem_wd[i*ADDR_W +: ADDR_W];
      wreg_pad[i]           = mem_wreg[i];
    end
  end

  assign san_full   = sanitize_wreg(wd_pad, wreg_pad);
  assign san_wreg   = san_full[NUM_PORTS-1:0];
  assign unused_san = ^san_full;

  assign accept   = mem_valid && mem_ready;
  assign xfer     = out_valid && wb_ready;
  assign wb_valid = out_valid;

`ifdef MEM_WB_SKID_EN
  logic                        skid_valid, skid_load, skid_clear;
  logic [NUM_PORTS*DATA_W-1:0] skid_wdata;
  logic [NUM_PORTS*ADDR_W-1:0] skid_wd;
  logic [NUM_PORTS-1:0]        skid_wreg;

  // Skid full is the only reason to stall, so wb_ready never reaches mem_ready.
  assign mem_ready = !skid_valid;

  always_comb begin
    out_load    = 1'b0;
    out_clear   = flush;
    skid_load   = 1'b0;
    skid_clear  = flush;
    out_d_wdata = mem_wdata;
    out_d_wd    = mem_wd;
    out_d_wreg  = san_wreg;
    if (!flush) begin
      if (skid_valid && xfer) begin
        out_load    = 1'b1;
        out_d_wdata = skid_wdata;
        out_d_wd    = skid_wd;
        out_d_wreg  = skid_wreg;
        skid_clear  = 1'b1;
      end else if (accept && (!out_valid || xfer)) begin
        out_load = 1'b1;
      end else if (accept) begin
        skid_load = 1'b1;
      end else if (xfer) begin
        out_clear = 1'b1;
      end
    end
  end

  pipe_skid_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_PORTS(NUM_PORTS)) u_skid (
    .clk     (clk),
    .rst     (resetn),
    .load    (skid_load),
    .clear   (skid_clear),
    .d_wdata (mem_wdata),
    .d_wd    (mem_wd),
    .d_wreg  (san_wreg),
    .valid   (skid_valid),
    .q_wdata (skid_wdata),
    .q_wd    (skid_wd),
    .q_wreg  (skid_wreg)
  );
`else
  assign mem_ready = !out_valid || wb_ready;

  always_comb begin
    out_load    = !flush && accept;
    out_clear   = flush || (xfer && !accept);
    out_d_wdata = mem_wdata;
    out_d_wd    = mem_wd;
    out_d_wreg  = san_wreg;
  end
`endif

  pipe_skid_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_PORTS(NUM_PORTS)) u_out (
    .clk     (clk),
    .rst     (resetn),
    .load    (out_load),
    .clear   (out_clear),
    .d_wdata (out_d_wdata),
    .d_wd    (out_d_wd),
    .d_wreg  (out_d_wreg),
    .valid   (out_valid),
    .q_wdata (wb_wdata),
    .q_wd    (wb_wd),
    .q_wreg  (wb_wreg)
  );

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe (two channels); works with or without MEM_WB_SKID_EN.
module tb_mem_wb_pipe;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NP = 2;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic flush = 1'b0, mem_valid = 1'b0, wb_ready = 1'b0;
  logic mem_ready, wb_valid;
  logic [NP*DW-1:0] mem_wdata = '0, wb_wdata;
  logic [NP*AW-1:0] mem_wd = '0, wb_wd;
  logic [NP-1:0]    mem_wreg = '0, wb_wreg;

  always #5 clk = ~clk;

  mem_wb_pipe #(.DATA_W(DW), .ADDR_W(AW), .NUM_PORTS(NP)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_wdata(wb_wdata), .wb_wd(wb_wd), .wb_wreg(wb_wreg)
  );

  typedef struct packed {
    logic [NP*DW-1:0] wdata;
    logic [NP*AW-1:0] wd;
    logic [NP-1:0]    wreg;
  } beat_t;

  beat_t q[$];
  int n_vec = 0, n_err = 0;
  beat_t prev;
  bit hold_prev = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A channel writes iff enabled, not r0, and no later enabled channel names the same register.
  function automatic beat_t model(input logic [NP*DW-1:0] d, input logic [NP*AW-1:0] a,
                                  input logic [NP-1:0] w);
    beat_t b;
    bit shadowed;
    b.wdata = d;
    b.wd    = a;
    b.wreg  = '0;
    for (int i = 0; i < NP; i++) begin
      shadowed = 0;
      for (int j = i + 1; j < NP; j++)
        if (w[j] && a[j*AW +: AW] == a[i*AW +: AW]) shadowed = 1;
      b.wreg[i] = w[i] && (a[i*AW +: AW] != '0) && !shadowed;
    end
    return b;
  endfunction

  // Stimulus side: every accepted beat's expected write-back goes on the queue.
  always @(posedge clk)
    if (!resetn && !flush && mem_valid && mem_ready)
      q.push_back(model(mem_wdata, mem_wd, mem_wreg));

  // Monitor: every transfer out is popped and compared; flush empties the model.
  always @(posedge clk)
    if (!resetn) begin
      if (wb_valid && wb_ready) begin
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_beat: got wd %0h with nothing expected at %0t", wb_wd, $time);
        end else begin
          beat_t e;
          e = q.pop_front();
          chk("xfer_wdata", wb_wdata, e.wdata);
          chk("xfer_wd",    wb_wd,    e.wd);
          chk("xfer_wreg",  wb_wreg,  e.wreg);
        end
      end
      if (flush) q.delete();
    end

  // Status checks mid-cycle: occupancy, ready, idle enables and hold stability.
  always @(negedge clk)
    if (resetn) hold_prev = 0;
    else begin
      chk("valid_occupancy", wb_valid, q.size() != 0);
      if (!wb_valid) chk("idle_wreg", wb_wreg, '0);
`ifdef MEM_WB_SKID_EN
      chk("mem_ready", mem_ready, q.size() < 2);
`else
      chk("mem_ready", mem_ready, q.size() == 0 || wb_ready);
`endif
      if (hold_prev) begin
        chk("hold_wdata", wb_wdata, prev.wdata);
        chk("hold_wd",    wb_wd,    prev.wd);
        chk("hold_wreg",  wb_wreg,  prev.wreg);
      end
      hold_prev = wb_valid && !wb_ready && !flush;
      prev = '{wdata: wb_wdata, wd: wb_wd, wreg: wb_wreg};
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [NP*DW-1:0] d, input logic [NP*AW-1:0] a,
                       input logic [NP-1:0] w);
    mem_valid = v; mem_wdata = d; mem_wd = a; mem_wreg = w;
  endtask

  initial begin
    tick(); tick();
    chk("rst_valid", wb_valid, 0);
    chk("rst_wdata", wb_wdata, 0);
    chk("rst_wd",    wb_wd,    0);
    chk("rst_wreg",  wb_wreg,  0);
    chk("rst_ready", mem_ready, 1);
    resetn = 0;

    // Single beat, then asynchronous reset mid-cycle.
    wb_ready = 1;
    offer(1, {32'h0, 32'hDEADBEEF}, {5'd0, 5'd5}, 2'b01);
    tick();
    offer(0, '0, '0, '0);
    chk("t1_valid", wb_valid, 1);
    chk("t1_wd",    wb_wd,    {5'd0, 5'd5});
    chk("t1_wdata", wb_wdata, {32'h0, 32'hDEADBEEF});
    chk("t1_wreg",  wb_wreg,  2'b01);
    resetn = 1;
    q.delete();
    #1;
    chk("arst_valid", wb_valid, 0);
    chk("arst_wdata", wb_wdata, 0);
    chk("arst_wd",    wb_wd,    0);
    chk("arst_wreg",  wb_wreg,  0);
    tick();
    resetn = 0;

    // Back-pressure for three cycles while A then B are offered.
    wb_ready = 0;
    offer(1, {32'h0, 32'hA0A0A0A0}, {5'd0, 5'd3}, 2'b01);
    tick();
    offer(1, {32'h0, 32'hB0B0B0B0}, {5'd0, 5'd4}, 2'b01);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_A", wb_wdata, {32'h0, 32'hA0A0A0A0});
      chk("hold_ready_low", mem_ready, 0);
    end
`ifdef MEM_WB_SKID_EN
    offer(0, '0, '0, '0);
    wb_ready = 1;
    tick();
`else
    wb_ready = 1;
    tick();
    offer(0, '0, '0, '0);
`endif
    chk("then_B", wb_wdata, {32'h0, 32'hB0B0B0B0});
    chk("then_B_valid", wb_valid, 1);
    tick();
    chk("drained_AB", wb_valid, 0);

    // r0 suppression keeps the data.
    offer(1, {32'h0, 32'h1234}, {5'd0, 5'd0}, 2'b01);
    tick();
    offer(0, '0, '0, '0);
    chk("r0_valid", wb_valid, 1);
    chk("r0_wreg",  wb_wreg,  2'b00);
    chk("r0_wdata", wb_wdata, {32'h0, 32'h1234});
    tick();

    // Same-address collision: channel 1 wins; distinct addresses both write.
    offer(1, {32'h1111, 32'h2222}, {5'd7, 5'd7}, 2'b11);
    tick();
    chk("coll_wreg", wb_wreg, 2'b10);
    offer(1, {32'h3333, 32'h4444}, {5'd8, 5'd7}, 2'b11);
    tick();
    chk("nocoll_wreg", wb_wreg, 2'b11);
    offer(0, '0, '0, '0);
    tick();

    // Flush with a held beat, a possibly skidded beat and an incoming beat.
    wb_ready = 0;
    offer(1, {32'h0, 32'hAAAA0001}, {5'd0, 5'd9}, 2'b01);
    tick();
    offer(1, {32'h0, 32'hAAAA0002}, {5'd0, 5'd10}, 2'b01);
    tick();
    offer(1, {32'h0, 32'hCCCC0003}, {5'd0, 5'd11}, 2'b01);
    flush = 1;
    tick();
    flush = 0;
    offer(0, '0, '0, '0);
    chk("flush_valid", wb_valid, 0);
    chk("flush_wreg",  wb_wreg,  0);
    chk("flush_ready", mem_ready, 1);
    wb_ready = 1;
    repeat (3) tick();

    // Random traffic; r0 and collisions are frequent with a 0..3 address range.
    for (int c = 0; c < 10000; c++) begin
      wb_ready  = ($urandom % 4) != 0;
      flush     = ($urandom % 50) == 0;
      offer(($urandom % 4) != 0, {$urandom, $urandom},
            {5'($urandom % 4), 5'($urandom % 4)}, 2'($urandom));
      tick();
    end
    flush = 0;
    wb_ready = 1;
    offer(0, '0, '0, '0);
    repeat (4) tick();
    chk("drain_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
